// File: rtl/tmc_spi_responder_pkg.sv
// Shared definitions for the stepper-driver SPI responder: frame length,
// register addresses, status-bit positions and the FSM state type.
package tmc_spi_responder_pkg;

    localparam int FRAME_BITS = 40;

    localparam logic [6:0] ADDR_GCONF      = 7'h00;
    localparam logic [6:0] ADDR_GSTAT      = 7'h01;
    localparam logic [6:0] ADDR_IHOLD_IRUN = 7'h10;
    localparam logic [6:0] ADDR_TPOWERDOWN = 7'h11;
    localparam logic [6:0] ADDR_TSTEP      = 7'h12;
    localparam logic [6:0] ADDR_TPWMTHRS   = 7'h13;
    localparam logic [6:0] ADDR_THIGH      = 7'h15;
    localparam logic [6:0] ADDR_CHOPCONF   = 7'h6C;
    localparam logic [6:0] ADDR_PWMCONF    = 7'h70;

    localparam logic [1:0] GSTAT_RESET = 2'b01;

    localparam int STAT_RESET_BIT      = 0;
    localparam int STAT_DRV_ERR_BIT    = 1;
    localparam int STAT_STANDSTILL_BIT = 3;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SHIFT  = 2'd1,
        ST_COMMIT = 2'd2
    } resp_state_t;

    function automatic logic [7:0] status_byte(input logic [1:0] gstat,
                                               input logic       standstill);
        logic [7:0] s;
        s = '0;
        s[STAT_RESET_BIT]      = gstat[0];
        s[STAT_DRV_ERR_BIT]    = gstat[1];
        s[STAT_STANDSTILL_BIT] = standstill;
        return s;
    endfunction

endpackage

// File: rtl/tmc_spi_responder_pin_sync.sv
// Two-flop synchroniser for one SPI pin with rise/fall detection on the
// synchronised level. RST_VAL is the idle level of the pin.
module spi_pin_sync #(
    parameter logic RST_VAL = 1'b0
) (
    input  logic clk_in,
    input  logic reset_in,
    input  logic pin_in,
    output logic level_out,
    output logic rise_out,
    output logic fall_out
);

    logic s_p0, s_p1, s_p2;

    always_ff @(posedge clk_in or posedge reset_in) begin
        if (reset_in) begin
            s_p0 <= RST_VAL;
            s_p1 <= RST_VAL;
            s_p2 <= RST_VAL;
        end else begin
            s_p0 <= pin_in;
            s_p1 <= s_p0;
            s_p2 <= s_p1;
        end
    end

    assign level_out = s_p1;
    assign rise_out  = s_p1 & ~s_p2;
    assign fall_out  = ~s_p1 & s_p2;

endmodule

// File: rtl/tmc_spi_responder.sv
// SPI mode-3 responder modelling the stepper driver's 40-bit register frame.
// Define SPI_RESP_LEN_CHECK_EN to reject frames that are not exactly 40 bits.
module tmc_spi_responder
    import tmc_spi_responder_pkg::*;
(
    input  logic        clk_in,
    input  logic        reset_in,
    input  logic        sclk_in,
    input  logic        cs_n_in,
    input  logic        serial_in,
    output logic        serial_out,
    output logic        serial_oe_out,
    input  logic        drv_err_in,
    input  logic        standstill_in,
    input  logic [19:0] tstep_in,
    output logic [31:0] gconf_out,
    output logic [31:0] chopconf_out,
    output logic [31:0] ihold_irun_out,
    output logic        wr_strobe_out,
    output logic [6:0]  wr_addr_out,
    output logic        frame_err_out
);

    logic sclk_lvl, sclk_rise, sclk_fall;
    logic cs_lvl, cs_rise, cs_fall;
    logic mosi_lvl, mosi_rise, mosi_fall;

    spi_pin_sync #(.RST_VAL(1'b1)) u_sync_sclk (
        .clk_in(clk_in), .reset_in(reset_in), .pin_in(sclk_in),
        .level_out(sclk_lvl), .rise_out(sclk_rise), .fall_out(sclk_fall)
    );
    spi_pin_sync #(.RST_VAL(1'b1)) u_sync_cs (
        .clk_in(clk_in), .reset_in(reset_in), .pin_in(cs_n_in),
        .level_out(cs_lvl), .rise_out(cs_rise), .fall_out(cs_fall)
    );
    spi_pin_sync #(.RST_VAL(1'b0)) u_sync_mosi (
        .clk_in(clk_in), .reset_in(reset_in), .pin_in(serial_in),
        .level_out(mosi_lvl), .rise_out(mosi_rise), .fall_out(mosi_fall)
    );

    logic unused_sync;
    assign unused_sync = &{1'b0, sclk_lvl, mosi_rise, mosi_fall};

    resp_state_t state, state_nxt;

    logic [39:0] tx_sr, rx_sr;
    logic [5:0]  bit_cnt;
    logic [31:0] read_latch;
    logic [1:0]  gstat;
    logic [31:0] gconf, ihold_irun, tpowerdown, tpwmthrs, thigh, chopconf, pwmconf;

    logic        rx_wr;
    logic [6:0]  rx_addr;
    logic [31:0] rx_data;
    logic        frame_ok;
    logic [31:0] rd_val;
    logic [1:0]  gstat_clr;

    assign rx_wr   = rx_sr[39];
    assign rx_addr = rx_sr[38:32];
    assign rx_data = rx_sr[31:0];

    always_ff @(posedge clk_in or posedge reset_in) begin
        if (reset_in) state <= ST_IDLE;
        else          state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:   if (cs_fall) state_nxt = ST_SHIFT;
            ST_SHIFT:  if (cs_rise) state_nxt = ST_COMMIT;
            ST_COMMIT: state_nxt = ST_IDLE;
            default:   state_nxt = ST_IDLE;
        endcase
    end

    // Length policy: count saturates at 63, rx_sr always holds the last 40 bits
`ifdef SPI_RESP_LEN_CHECK_EN
    logic frame_bad, frame_err_q;
    assign frame_ok  = (state == ST_COMMIT) && (bit_cnt == 6'(FRAME_BITS));
    assign frame_bad = (state == ST_COMMIT) && (bit_cnt != 6'd0) &&
                       (bit_cnt != 6'(FRAME_BITS));

    always_ff @(posedge clk_in or posedge reset_in) begin
        if (reset_in) frame_err_q <= 1'b0;
        else          frame_err_q <= frame_bad;
    end
    assign frame_err_out = frame_err_q;
`else
    assign frame_ok      = (state == ST_COMMIT) && (bit_cnt >= 6'(FRAME_BITS));
    assign frame_err_out = 1'b0;
`endif

    always_comb begin
        rd_val = '0;
        case (rx_addr)
            ADDR_GCONF:      rd_val = gconf;
            ADDR_GSTAT:      rd_val = {30'b0, gstat};
            ADDR_IHOLD_IRUN: rd_val = ihold_irun;
            ADDR_TPOWERDOWN: rd_val = tpowerdown;
            ADDR_TSTEP:      rd_val = {12'b0, tstep_in};
            ADDR_TPWMTHRS:   rd_val = tpwmthrs;
            ADDR_THIGH:      rd_val = thigh;
            ADDR_CHOPCONF:   rd_val = chopconf;
            ADDR_PWMCONF:    rd_val = pwmconf;
            default:         rd_val = '0;
        endcase
    end

    // GSTAT: write-1-to-clear on write, full clear on read (after latching)
    always_comb begin
        gstat_clr = '0;
        if (frame_ok && (rx_addr == ADDR_GSTAT))
            gstat_clr = rx_wr ? rx_data[1:0] : 2'b11;
    end

    always_ff @(posedge clk_in or posedge reset_in) begin
        if (reset_in) gstat <= GSTAT_RESET;
        else          gstat <= (gstat & ~gstat_clr) | {drv_err_in, 1'b0};
    end

    // Shift path: tx advances only after the first sampling edge so that the
    // MSB stays on the line through the first mode-3 falling edge
    always_ff @(posedge clk_in or posedge reset_in) begin
        if (reset_in) begin
            tx_sr      <= '0;
            rx_sr      <= '0;
            bit_cnt    <= '0;
            serial_out <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    serial_out <= 1'b0;
                    if (cs_fall) begin
                        tx_sr      <= {status_byte(gstat, standstill_in), read_latch};
                        bit_cnt    <= '0;
                        serial_out <= status_byte(gstat, standstill_in)[7];
                    end
                end
                ST_SHIFT: begin
                    if (cs_rise) begin
                        serial_out <= 1'b0;
                    end else begin
                        if (sclk_rise) begin
                            rx_sr <= {rx_sr[38:0], mosi_lvl};
                            if (bit_cnt != 6'd63) bit_cnt <= bit_cnt + 6'd1;
                        end
                        if (sclk_fall && (bit_cnt != 6'd0)) begin
                            tx_sr      <= {tx_sr[38:0], 1'b0};
                            serial_out <= tx_sr[38];
                        end
                    end
                end
                default: serial_out <= 1'b0;
            endcase
        end
    end

    always_ff @(posedge clk_in or posedge reset_in) begin
        if (reset_in) serial_oe_out <= 1'b0;
        else          serial_oe_out <= ~cs_lvl;
    end

    // Commit stage: register file, reply latch and write strobe
    always_ff @(posedge clk_in or posedge reset_in) begin
        if (reset_in) begin
            gconf         <= '0;
            ihold_irun    <= '0;
            tpowerdown    <= '0;
            tpwmthrs      <= '0;
            thigh         <= '0;
            chopconf      <= '0;
            pwmconf       <= '0;
            read_latch    <= '0;
            wr_strobe_out <= 1'b0;
            wr_addr_out   <= '0;
        end else begin
            wr_strobe_out <= 1'b0;
            if (frame_ok && rx_wr) begin
                case (rx_addr)
                    ADDR_GCONF:      gconf      <= rx_data;
                    ADDR_IHOLD_IRUN: ihold_irun <= rx_data;
                    ADDR_TPOWERDOWN: tpowerdown <= rx_data;
                    ADDR_TPWMTHRS:   tpwmthrs   <= rx_data;
                    ADDR_THIGH:      thigh      <= rx_data;
                    ADDR_CHOPCONF:   chopconf   <= rx_data;
                    ADDR_PWMCONF:    pwmconf    <= rx_data;
                    default: ;
                endcase
                read_latch    <= rx_data;
                wr_strobe_out <= 1'b1;
                wr_addr_out   <= rx_addr;
            end else if (frame_ok) begin
                read_latch <= rd_val;
            end
        end
    end

    assign gconf_out      = gconf;
    assign chopconf_out   = chopconf;
    assign ihold_irun_out = ihold_irun;

endmodule

// File: tb/tb_tmc_spi_responder.sv
// Directed bench for tmc_spi_responder: mode-3 frames driven bit by bit,
// replies and register outputs compared against hand-computed values.
module tb_tmc_spi_responder;

    logic        clk_in = 1'b0;
    logic        reset_in = 1'b1;
    logic        sclk_in = 1'b1;
    logic        cs_n_in = 1'b1;
    logic        serial_in = 1'b0;
    logic        serial_out, serial_oe_out;
    logic        drv_err_in = 1'b0;
    logic        standstill_in = 1'b0;
    logic [19:0] tstep_in = 20'h12345;
    logic [31:0] gconf_out, chopconf_out, ihold_irun_out;
    logic        wr_strobe_out;
    logic [6:0]  wr_addr_out;
    logic        frame_err_out;

    int n_cmp = 0;
    int n_err = 0;
    int n_strobe = 0;
    int n_ferr = 0;

    always #5 clk_in = ~clk_in;

    tmc_spi_responder dut (
        .clk_in(clk_in), .reset_in(reset_in), .sclk_in(sclk_in), .cs_n_in(cs_n_in),
        .serial_in(serial_in), .serial_out(serial_out), .serial_oe_out(serial_oe_out),
        .drv_err_in(drv_err_in), .standstill_in(standstill_in), .tstep_in(tstep_in),
        .gconf_out(gconf_out), .chopconf_out(chopconf_out), .ihold_irun_out(ihold_irun_out),
        .wr_strobe_out(wr_strobe_out), .wr_addr_out(wr_addr_out), .frame_err_out(frame_err_out)
    );

    always @(negedge clk_in) begin
        if (wr_strobe_out) n_strobe++;
        if (frame_err_out) n_ferr++;
    end

    task automatic wait_cyc(input int n);
        repeat (n) @(negedge clk_in);
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic xfer_bit(input logic b, output logic m);
        sclk_in   = 1'b0;
        serial_in = b;
        wait_cyc(8);
        m = serial_out;
        sclk_in = 1'b1;
        wait_cyc(8);
    endtask

    task automatic spi_frame(input int nbits, input logic [63:0] bits,
                             output logic [63:0] reply, output logic oe_mid);
        logic m;
        reply   = '0;
        cs_n_in = 1'b0;
        wait_cyc(8);
        oe_mid = serial_oe_out;
        for (int i = nbits - 1; i >= 0; i--) begin
            xfer_bit(bits[i], m);
            reply = {reply[62:0], m};
        end
        cs_n_in = 1'b1;
        wait_cyc(12);
    endtask

    initial begin
        logic [63:0] rep;
        logic        oe;
        int          s0, f0;
        logic        m;

        // Reset state
        wait_cyc(5);
        chk("rst_miso", serial_out, 1'b0);
        chk("rst_oe", serial_oe_out, 1'b0);
        chk("rst_gconf", gconf_out, 32'h0);
        chk("rst_chop", chopconf_out, 32'h0);
        chk("rst_ihold", ihold_irun_out, 32'h0);
        chk("rst_strobe", wr_strobe_out, 1'b0);
        chk("rst_ferr", frame_err_out, 1'b0);
        reset_in = 1'b0;
        wait_cyc(5);

        // Two reads of GCONF after reset
        spi_frame(40, {24'h0, 8'h00, 32'h0}, rep, oe);
        chk("oe_mid", oe, 1'b1);
        chk("rd1_status", rep[39:32], 8'h01);
        chk("rd1_data", rep[31:0], 32'h0);
        spi_frame(40, {24'h0, 8'h00, 32'h0}, rep, oe);
        chk("rd2_status", rep[39:32], 8'h01);
        chk("rd2_data", rep[31:0], 32'h0);

        // Write GCONF, then read back twice
        s0 = n_strobe;
        spi_frame(40, {24'h0, 8'h80, 32'h00000022}, rep, oe);
        chk("wr_strobe_cnt", n_strobe - s0, 1);
        chk("wr_addr", wr_addr_out, 7'h00);
        chk("gconf_wr", gconf_out, 32'h22);
        spi_frame(40, {24'h0, 8'h00, 32'h0}, rep, oe);
        chk("echo_data", rep[31:0], 32'h22);
        spi_frame(40, {24'h0, 8'h00, 32'h0}, rep, oe);
        chk("rdback_data", rep[31:0], 32'h22);

        // CHOPCONF and IHOLD_IRUN
        spi_frame(40, {24'h0, 8'hEC, 32'h30088188}, rep, oe);
        spi_frame(40, {24'h0, 8'h90, 32'h00081F1F}, rep, oe);
        chk("chop_echo", rep[31:0], 32'h30088188);
        chk("chopconf", chopconf_out, 32'h30088188);
        chk("ihold_irun", ihold_irun_out, 32'h00081F1F);
        chk("ihold_addr", wr_addr_out, 7'h10);

        // GSTAT clear-on-read
        spi_frame(40, {24'h0, 8'h01, 32'h0}, rep, oe);
        chk("gs1_status", rep[39:32], 8'h01);
        chk("gs1_data", rep[31:0], 32'h00081F1F);
        spi_frame(40, {24'h0, 8'h01, 32'h0}, rep, oe);
        chk("gs2_status", rep[39:32], 8'h00);
        chk("gs2_data", rep[31:0], 32'h1);

        // drv_err sets bit1, standstill shows in bit3
        drv_err_in = 1'b1;
        wait_cyc(2);
        drv_err_in = 1'b0;
        standstill_in = 1'b1;
        wait_cyc(2);
        spi_frame(40, {24'h0, 8'h00, 32'h0}, rep, oe);
        chk("err_status", rep[39:32], 8'h0A);
        chk("gs3_data", rep[31:0], 32'h0);

        // W1C write to GSTAT
        s0 = n_strobe;
        spi_frame(40, {24'h0, 8'h81, 32'h00000002}, rep, oe);
        chk("w1c_status", rep[39:32], 8'h0A);
        chk("w1c_reply", rep[31:0], 32'h22);
        chk("w1c_strobe", n_strobe - s0, 1);
        chk("w1c_addr", wr_addr_out, 7'h01);
        standstill_in = 1'b0;
        wait_cyc(2);

        // TSTEP and an unimplemented address
        spi_frame(40, {24'h0, 8'h12, 32'h0}, rep, oe);
        chk("w1c_cleared", rep[39:32], 8'h00);
        chk("w1c_echo", rep[31:0], 32'h2);
        spi_frame(40, {24'h0, 8'h05, 32'h0}, rep, oe);
        chk("tstep_data", rep[31:0], 32'h00012345);
        spi_frame(40, {24'h0, 8'h00, 32'h0}, rep, oe);
        chk("unimpl_data", rep[31:0], 32'h0);

        // 39-bit frame
        s0 = n_strobe;
        f0 = n_ferr;
        spi_frame(39, {25'h0, 39'h40_0000_0077}, rep, oe);
        chk("short_strobe", n_strobe - s0, 0);
        chk("short_gconf", gconf_out, 32'h22);
`ifdef SPI_RESP_LEN_CHECK_EN
        chk("short_ferr", n_ferr - f0, 1);
`else
        chk("short_ferr", n_ferr - f0, 0);
`endif

        // 48-bit frame: last 40 bits are a GCONF write
        s0 = n_strobe;
        f0 = n_ferr;
        spi_frame(48, {16'h0, 8'hAA, 8'h80, 32'h00000055}, rep, oe);
`ifdef SPI_RESP_LEN_CHECK_EN
        chk("long_ferr", n_ferr - f0, 1);
        chk("long_strobe", n_strobe - s0, 0);
        chk("long_gconf", gconf_out, 32'h22);
`else
        chk("long_ferr", n_ferr - f0, 0);
        chk("long_strobe", n_strobe - s0, 1);
        chk("long_gconf", gconf_out, 32'h55);
        chk("long_addr", wr_addr_out, 7'h00);
`endif

        // Reset after 20 bits of a write
        s0 = n_strobe;
        cs_n_in = 1'b0;
        wait_cyc(8);
        for (int i = 39; i >= 20; i--) begin
            xfer_bit(i == 39 ? 1'b1 : ((i % 3) == 0), m);
        end
        reset_in = 1'b1;
        wait_cyc(3);
        chk("mid_rst_miso", serial_out, 1'b0);
        reset_in = 1'b0;
        wait_cyc(3);
        cs_n_in = 1'b1;
        wait_cyc(12);
        chk("mid_rst_strobe", n_strobe - s0, 0);
        chk("mid_rst_gconf", gconf_out, 32'h0);
        chk("mid_rst_chop", chopconf_out, 32'h0);
        chk("mid_rst_miso_end", serial_out, 1'b0);
        spi_frame(40, {24'h0, 8'h00, 32'h0}, rep, oe);
        chk("post_rst_status", rep[39:32], 8'h01);
        chk("post_rst_data", rep[31:0], 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/tmc_spi_responder.md
# tmc_spi_responder

SPI target (responder) model of the stepper driver chip's 40-bit register interface, answering the frames our SPI initiator sends during driver setup. It sits on the far end of the cs/sclk/mosi/miso link, either in simulation benches or in the FPGA as a loopback target. It holds a subset of the driver's register file, applies writes, returns the SPI status byte plus read data, and exposes the configured register values to downstream logic.

## Interface
- No parameters; frame length is fixed at 40 bits (8 address + 32 data).
- clk_in  input  1  system clock; samples all SPI pins.
- reset_in  input  1  asynchronous, active-high reset.
- sclk_in  input  1  SPI clock, mode 3 (idle high).
- cs_n_in  input  1  chip select, active low.
- serial_in  input  1  MOSI.
- serial_out  output  1  MISO; 0 while deselected.
- serial_oe_out  output  1  high while cs_n_in is low (synchronised).
- drv_err_in  input  1  driver error flag into GSTAT[1].
- standstill_in  input  1  status bit 3.
- tstep_in  input  20  value returned by TSTEP (0x12).
- gconf_out, chopconf_out, ihold_irun_out  output  32 each  current register values.
- wr_strobe_out  output  1  one-cycle pulse per committed write.
- wr_addr_out  output  7  address of last committed write.
- frame_err_out  output  1  one-cycle pulse on a rejected frame.

## Operation
- sclk_in, cs_n_in, serial_in pass through 2-flop synchronisers; edges detected on synchronised values.
- States: IDLE (cs high) -> SHIFT (cs low) -> COMMIT (one cycle after cs rise) -> IDLE.
- On cs fall: load tx shift register with {status[7:0], read_latch[31:0]}, bit count <= 0, serial_out <= tx[39].
- SHIFT: sclk rising edge samples serial_in into rx shift (MSB first), count increments (saturating at 63); sclk falling edge shifts tx, serial_out <= next bit.
- Status byte: {4'b0, standstill_in, 1'b0, gstat[1], gstat[0]}.
- COMMIT decodes rx[39]=write flag, rx[38:32]=address, rx[31:0]=data.
- Writable: GCONF 0x00, IHOLD_IRUN 0x10, TPOWERDOWN 0x11, TPWMTHRS 0x13, THIGH 0x15, CHOPCONF 0x6C, PWMCONF 0x70. GSTAT 0x01 is write-1-to-clear. TSTEP read-only. Other addresses: writes ignored, reads return 0.
- Write: register updated, read_latch <= written data, wr_strobe_out pulses, wr_addr_out updated (also for ignored addresses).
- Read: read_latch <= register value; GSTAT read also clears GSTAT (clear-on-read after latching).
- gstat[0] (reset flag) =1 after reset; gstat[1] set while drv_err_in high, sticky until cleared.
- Reset values: all registers 0 except GSTAT=0x1; read_latch 0; serial_out 0; serial_oe_out 0; strobes 0.

## Timing
- Pin-to-internal latency 3 clk_in cycles (2 sync + edge detect).
- sclk_in high and low phases each ≥ 4 clk_in cycles; cs_n_in fall to first sclk fall ≥ 4 cycles.
- serial_out valid 3 cycles after cs fall and 3 cycles after each sclk fall.
- wr_strobe_out / frame_err_out assert 4 cycles after cs_n_in rises, for one cycle; register outputs update on that same cycle.
- Reply data of frame N = read_latch from frame N-1.
- Simultaneous GSTAT clear and drv_err_in high: set wins.
- reset_in mid-frame: immediate return to IDLE, frame discarded, no strobe.
- cs rise with count 0: nothing committed, no error.

## Configuration
- SPI_RESP_LEN_CHECK_EN defined: commit only if count == 40; any other nonzero count discards frame and pulses frame_err_out.
- Undefined: commit if count ≥ 40 using the last 40 bits received (daisy-chain behaviour); count 1..39 discarded silently, frame_err_out tied 0.

## Structure
- Shared package/header: register address constants (existing driver address defines), status-bit positions, FRAME_BITS=40, GSTAT reset value.
- One sub-module: spi_pin_sync (2-flop sync + rise/fall detect, instantiated per input).

## Test plan
- After reset, read GCONF (0x00): reply status 0x01, data 0; second frame reply data 0x00000000, GSTAT still shows bit0.
- Write 0x80/0x00000022 then read 0x00 twice: wr_strobe_out once with wr_addr_out 0x00; gconf_out=0x22; first read replies 0x22 (write echo), second 0x22.
- Write CHOPCONF 0xEC/0x30088188, IHOLD_IRUN 0x90/0x00081F1F: chopconf_out=0x30088188, ihold_irun_out=0x00081F1F.
- Read GSTAT twice after reset: second reply data 0x1, third frame status bit0 = 0 (cleared); drv_err_in pulse re-sets bit1.
- 39-bit frame with LEN_CHECK on: frame_err_out pulse, no register change; off: no pulse, no change; 48-bit frame off: last 40 bits committed.
- reset_in asserted after 20 sclk bits of a write: no wr_strobe_out, registers at reset values, serial_out 0.
